// File: rtl/pico9_io_sched_if.sv
// pico9_io_sched_if: tagged 9-bit valid/ready stream pair between the I/O scheduler and its link.
// master = scheduler side (drives tx words, accepts rx words); slave = link peer.
interface pico9_io_sched_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [8:0] tx_data;
    logic [1:0] tx_ch;
    logic       rx_valid;
    logic       rx_ready;
    logic [8:0] rx_data;
    logic [1:0] rx_ch;

    modport master (
        output tx_valid, tx_data, tx_ch, rx_ready,
        input  tx_ready, rx_valid, rx_data, rx_ch
    );

    modport slave (
        input  tx_valid, tx_data, tx_ch, rx_ready,
        output tx_ready, rx_valid, rx_data, rx_ch
    );
endinterface

// File: rtl/pico9_io_sched.sv
// pico9_io_sched: pico9 CPU port strobes <-> shared tagged stream, per-channel TX/RX FIFOs,
// round-robin TX arbiter. Define PICO9_IO_SCHED_IRQ_EN for the masked RX-not-empty interrupt.
module pico9_io_sched #(
    parameter int unsigned CH         = 2,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       port,
    input  logic             iord,
    input  logic             iowr,
    input  logic [8:0]       cpu_wdata,
    output logic [8:0]       cpu_rdata,
`ifdef PICO9_IO_SCHED_IRQ_EN
    output logic             irq,
`endif
    pico9_io_sched_if.master link
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned PW      = DEPTH_LOG2;
    localparam int unsigned CW      = DEPTH_LOG2 + 1;
    localparam logic [3:0]  CH_MASK = 4'((1 << CH) - 1);

    // Per-channel state is sized for the 4-channel maximum; channels >= CH never push or pop.
    logic [8:0]    tx_mem_q [4][DEPTH];
    logic [8:0]    rx_mem_q [4][DEPTH];
    logic [PW-1:0] tx_wp_q [4];
    logic [PW-1:0] tx_rp_q [4];
    logic [PW-1:0] rx_wp_q [4];
    logic [PW-1:0] rx_rp_q [4];
    logic [CW-1:0] tx_cnt_q [4];
    logic [CW-1:0] rx_cnt_q [4];

    logic [3:0] tx_full, tx_empty, rx_full, rx_empty;
    logic [3:0] tx_push, tx_pop, rx_push, rx_pop;

    logic       tx_valid_q, tx_valid_d;
    logic [8:0] tx_data_q, tx_data_d;
    logic [1:0] tx_ch_q, tx_ch_d;
    logic [1:0] rr_q, rr_d;
    logic       ovf_q, udf_q, badch_q;
    logic       ovf_d, udf_d, badch_d;

    logic [1:0] cpu_ch;
    logic       cpu_ch_ok, rx_ch_ok, ctrl_wr, flush, err_rd;
    logic       tx_load, grant_found;
    logic [1:0] grant_ch;
    logic [2:0] scan_idx;

    assign cpu_ch    = port[1:0];
    assign cpu_ch_ok = {29'd0, port} < CH;
    assign rx_ch_ok  = {30'd0, link.rx_ch} < CH;
    assign ctrl_wr   = iowr & (port == 3'd7);
    assign flush     = ctrl_wr & cpu_wdata[8];
    assign err_rd    = iord & (port == 3'd6);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            tx_full[k]  = tx_cnt_q[k] == CW'(DEPTH);
            tx_empty[k] = tx_cnt_q[k] == '0;
            rx_full[k]  = rx_cnt_q[k] == CW'(DEPTH);
            rx_empty[k] = rx_cnt_q[k] == '0;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            tx_push[k] = iowr & cpu_ch_ok & (cpu_ch == 2'(k)) & ~tx_full[k];
            rx_pop[k]  = iord & cpu_ch_ok & (cpu_ch == 2'(k)) & ~rx_empty[k];
            rx_push[k] = link.rx_valid & rx_ch_ok & (link.rx_ch == 2'(k)) & ~rx_full[k];
        end
    end

    assign link.rx_ready = rx_ch_ok ? ~rx_full[link.rx_ch] : 1'b1;

    // Round-robin scan starting at rr_q; sees FIFO state before this edge's CPU push.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = 2'd0;
        scan_idx    = 3'd0;
        for (int i = 0; i < int'(CH); i++) begin
            scan_idx = {1'b0, rr_q} + 3'(i);
            if (scan_idx >= 3'(CH)) begin
                scan_idx = scan_idx - 3'(CH);
            end
            if (!grant_found && !tx_empty[scan_idx[1:0]]) begin
                grant_found = 1'b1;
                grant_ch    = scan_idx[1:0];
            end
        end
    end

    always_comb begin
        tx_load    = ~tx_valid_q | link.tx_ready;
        tx_pop     = '0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_ch_d    = tx_ch_q;
        rr_d       = rr_q;
        if (tx_load) begin
            tx_valid_d = grant_found;
            if (grant_found) begin
                tx_pop[grant_ch] = 1'b1;
                tx_data_d        = tx_mem_q[grant_ch][tx_rp_q[grant_ch]];
                tx_ch_d          = grant_ch;
                rr_d             = (32'(grant_ch) + 32'd1 >= CH) ? 2'd0 : grant_ch + 2'd1;
            end
        end
    end

    // A set event in the same cycle as the clearing read keeps the flag high.
    always_comb begin
        ovf_d   = (iowr & cpu_ch_ok & tx_full[cpu_ch]) | (ovf_q & ~err_rd);
        udf_d   = (iord & cpu_ch_ok & rx_empty[cpu_ch]) | (udf_q & ~err_rd);
        badch_d = (link.rx_valid & ~rx_ch_ok) | (badch_q & ~err_rd);
    end

    always_comb begin
        cpu_rdata = '0;
        if (cpu_ch_ok) begin
            if (!rx_empty[cpu_ch]) begin
                cpu_rdata = rx_mem_q[cpu_ch][rx_rp_q[cpu_ch]];
            end
        end else if (port == 3'd6) begin
            cpu_rdata = {6'd0, badch_q, udf_q, ovf_q};
        end else if (port == 3'd7) begin
            cpu_rdata = {tx_valid_q, tx_full & CH_MASK, ~rx_empty & CH_MASK};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_ch_q    <= '0;
            rr_q       <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            badch_q    <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                tx_wp_q[k]  <= '0;
                tx_rp_q[k]  <= '0;
                tx_cnt_q[k] <= '0;
                rx_wp_q[k]  <= '0;
                rx_rp_q[k]  <= '0;
                rx_cnt_q[k] <= '0;
            end
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_ch_q    <= tx_ch_d;
            rr_q       <= rr_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            badch_q    <= badch_d;
            for (int k = 0; k < 4; k++) begin
                if (flush) begin
                    tx_wp_q[k]  <= '0;
                    tx_rp_q[k]  <= '0;
                    tx_cnt_q[k] <= '0;
                    rx_wp_q[k]  <= '0;
                    rx_rp_q[k]  <= '0;
                    rx_cnt_q[k] <= '0;
                end else begin
                    if (tx_push[k]) tx_wp_q[k] <= tx_wp_q[k] + PW'(1);
                    if (tx_pop[k])  tx_rp_q[k] <= tx_rp_q[k] + PW'(1);
                    if (rx_push[k]) rx_wp_q[k] <= rx_wp_q[k] + PW'(1);
                    if (rx_pop[k])  rx_rp_q[k] <= rx_rp_q[k] + PW'(1);
                    tx_cnt_q[k] <= tx_cnt_q[k] + CW'(tx_push[k]) - CW'(tx_pop[k]);
                    rx_cnt_q[k] <= rx_cnt_q[k] + CW'(rx_push[k]) - CW'(rx_pop[k]);
                end
            end
        end
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (tx_push[k]) tx_mem_q[k][tx_wp_q[k]] <= cpu_wdata;
            if (rx_push[k]) rx_mem_q[k][rx_wp_q[k]] <= link.rx_data;
        end
    end

    assign link.tx_valid = tx_valid_q;
    assign link.tx_data  = tx_data_q;
    assign link.tx_ch    = tx_ch_q;

`ifdef PICO9_IO_SCHED_IRQ_EN
    logic [3:0] mask_q;
    logic       irq_q;
    logic       unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (ctrl_wr) mask_q <= cpu_wdata[3:0];
            irq_q <= |(~rx_empty & mask_q);
        end
    end

    assign irq          = irq_q;
    assign unused_wdata = ^cpu_wdata[7:4];
`else
    logic unused_wdata;
    assign unused_wdata = ^cpu_wdata[7:0];
`endif

endmodule

// File: tb/tb_pico9_io_sched.sv
// tb_pico9_io_sched: directed + random stimulus against a queue-based reference model,
// TX words checked through a scoreboard queue popped on each link handshake.
module tb_pico9_io_sched;
    localparam int CH    = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] port = '0;
    logic       iord = 1'b0;
    logic       iowr = 1'b0;
    logic [8:0] cpu_wdata = '0;
    logic [8:0] cpu_rdata;
`ifdef PICO9_IO_SCHED_IRQ_EN
    logic       irq;
`endif

    pico9_io_sched_if link_if ();

    pico9_io_sched #(.CH(CH), .DEPTH_LOG2(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .port      (port),
        .iord      (iord),
        .iowr      (iowr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
`ifdef PICO9_IO_SCHED_IRQ_EN
        .irq       (irq),
`endif
        .link      (link_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: FIFOs as queues, errors as flags, output register as a valid bit.
    logic [8:0]  txq [4][$];
    logic [8:0]  rxq [4][$];
    logic [10:0] exp_q [$];
    bit          m_valid, m_ovf, m_udf, m_bad, m_irq;
    int          m_rr;
    logic [3:0]  m_mask;

    typedef struct {
        int cyc;
        int ch;
        int data;
    } seen_t;
    seen_t seen_q [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                txq[k].delete();
                rxq[k].delete();
            end
            exp_q.delete();
            m_valid = 0; m_rr = 0; m_ovf = 0; m_udf = 0; m_bad = 0; m_irq = 0; m_mask = '0;
        end else begin
            int p, g, rc;
            bit cpu_ch, pre_tfull, pre_rempty, rx_ok, pre_rfull, s_ovf, s_udf, s_bad;
            logic [8:0] w;
            p = int'(port);
            rc = int'(link_if.rx_ch);
            cpu_ch = p < CH;
            pre_tfull = 0;
            pre_rempty = 0;
            if (cpu_ch) begin
                pre_tfull  = txq[p].size() == DEPTH;
                pre_rempty = rxq[p].size() == 0;
            end
            rx_ok = rc < CH;
            pre_rfull = rx_ok ? (rxq[rc].size() == DEPTH) : 0;
            m_irq = 0;
            for (int k = 0; k < CH; k++) if (m_mask[k] && rxq[k].size() != 0) m_irq = 1;
            if (!m_valid || link_if.tx_ready) begin
                g = -1;
                for (int i = 0; i < CH; i++) begin
                    if (g < 0 && txq[(m_rr + i) % CH].size() != 0) g = (m_rr + i) % CH;
                end
                if (g >= 0) begin
                    w = txq[g].pop_front();
                    exp_q.push_back({2'(g), w});
                    m_valid = 1;
                    m_rr = (g + 1) % CH;
                end else begin
                    m_valid = 0;
                end
            end
            s_ovf = iowr && cpu_ch && pre_tfull;
            if (iowr && cpu_ch && !pre_tfull) txq[p].push_back(cpu_wdata);
            s_udf = iord && cpu_ch && pre_rempty;
            if (iord && cpu_ch && !pre_rempty) w = rxq[p].pop_front();
            s_bad = link_if.rx_valid && !rx_ok;
            if (link_if.rx_valid && rx_ok && !pre_rfull) rxq[rc].push_back(link_if.rx_data);
            if (iord && p == 6) begin
                m_ovf = 0; m_udf = 0; m_bad = 0;
            end
            m_ovf = m_ovf | s_ovf;
            m_udf = m_udf | s_udf;
            m_bad = m_bad | s_bad;
            if (iowr && p == 7) begin
                m_mask = cpu_wdata[3:0];
                if (cpu_wdata[8]) begin
                    for (int k = 0; k < 4; k++) begin
                        txq[k].delete();
                        rxq[k].delete();
                    end
                end
            end
        end
    end

    function automatic logic [8:0] m_rdata(input logic [2:0] pp);
        int q;
        logic [8:0] r;
        q = int'(pp);
        r = '0;
        if (q < CH) begin
            if (rxq[q].size() != 0) r = rxq[q][0];
        end else if (q == 6) begin
            r = {6'd0, m_bad, m_udf, m_ovf};
        end else if (q == 7) begin
            r[8] = m_valid;
            for (int k = 0; k < CH; k++) begin
                r[k]     = rxq[k].size() != 0;
                r[4 + k] = txq[k].size() == DEPTH;
            end
        end
        return r;
    endfunction

    function automatic bit m_rx_ready();
        int rc;
        rc = int'(link_if.rx_ch);
        if (rc < CH) return rxq[rc].size() < DEPTH;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            check("rdata", 32'(cpu_rdata), 32'(m_rdata(port)));
            check("rx_ready", 32'(link_if.rx_ready), 32'(m_rx_ready()));
            check("tx_valid", 32'(link_if.tx_valid), 32'(m_valid));
`ifdef PICO9_IO_SCHED_IRQ_EN
            check("irq", 32'(irq), 32'(m_irq));
`endif
            if (link_if.tx_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_word: got ch%0d 0x%0h expected nothing pending",
                             link_if.tx_ch, link_if.tx_data);
                end else begin
                    check("tx_word", 32'({link_if.tx_ch, link_if.tx_data}), 32'(exp_q[0]));
                    if (link_if.tx_ready) begin
                        exp_q.pop_front();
                        seen_q.push_back('{cyc, int'(link_if.tx_ch), int'(link_if.tx_data)});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [2:0] p, input logic [8:0] d);
        port = p; cpu_wdata = d; iowr = 1'b1;
        tick();
        iowr = 1'b0;
    endtask

    task automatic cpu_read_check(input string name, input logic [2:0] p, input logic [8:0] e);
        port = p; iord = 1'b1;
        @(negedge clk);
        check(name, 32'(cpu_rdata), 32'(e));
        tick();
        iord = 1'b0;
    endtask

    task automatic peek_check(input string name, input logic [2:0] p, input logic [8:0] e);
        port = p;
        @(negedge clk);
        check(name, 32'(cpu_rdata), 32'(e));
        tick();
    endtask

    task automatic rx_send(input logic [1:0] ch, input logic [8:0] d);
        link_if.rx_valid = 1'b1; link_if.rx_ch = ch; link_if.rx_data = d;
        tick();
        link_if.rx_valid = 1'b0;
    endtask

    task automatic check_seen(input string name, input int idx, input int ch, input int data);
        if (seen_q.size() > idx) begin
            check(name, 32'({seen_q[idx].ch, seen_q[idx].data}), 32'({ch, data}));
        end else begin
            check(name, 32'(seen_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int op;
        link_if.tx_ready = 1'b0;
        link_if.rx_valid = 1'b0;
        link_if.rx_ch = '0;
        link_if.rx_data = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset with traffic queued in both directions.
        cpu_write(3'd0, 9'h011);
        cpu_write(3'd1, 9'h022);
        cpu_write(3'd0, 9'h012);
        rx_send(2'd0, 9'h033);
        rx_send(2'd1, 9'h034);
        reset_n = 1'b0;
        #1;
        check("rst_tx_valid", 32'(link_if.tx_valid), 32'd0);
        check("rst_tx_word", 32'({link_if.tx_ch, link_if.tx_data}), 32'd0);
        port = 3'd7;
        #1 check("rst_status", 32'(cpu_rdata), 32'h000);
        port = 3'd6;
        #1 check("rst_err", 32'(cpu_rdata), 32'h000);
        @(posedge clk);
        #1 reset_n = 1'b1;
        peek_check("post_rst_status", 3'd7, 9'h000);
        peek_check("post_rst_err", 3'd6, 9'h000);

        // Back-to-back transfer from two channels.
        seen_q.delete();
        link_if.tx_ready = 1'b1;
        cpu_write(3'd0, 9'h1A5);
        cpu_write(3'd1, 9'h0F0);
        repeat (5) tick();
        check_seen("b2b_first", 0, 0, 'h1A5);
        check_seen("b2b_second", 1, 1, 'h0F0);
        if (seen_q.size() >= 2) check("b2b_gap", 32'(seen_q[1].cyc - seen_q[0].cyc), 32'd1);

        // Round-robin interleave under a toggling ready.
        seen_q.delete();
        link_if.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) cpu_write(3'd0, 9'(9'h010 + i));
        for (int i = 0; i < 3; i++) cpu_write(3'd1, 9'(9'h020 + i));
        for (int i = 0; i < 20; i++) begin
            link_if.tx_ready = (i % 2) == 0;
            tick();
        end
        check("rr_count", 32'(seen_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_seen("rr_order", i, i % 2, ((i % 2) ? 'h020 : 'h010) + i / 2);
        end

        // Overflow with the output register already occupied.
        seen_q.delete();
        link_if.tx_ready = 1'b0;
        cpu_write(3'd1, 9'h055);
        for (int i = 0; i < 5; i++) cpu_write(3'd0, 9'(9'h0A0 + i));
        peek_check("ovf_status", 3'd7, 9'h110);
        cpu_read_check("ovf_err", 3'd6, 9'h001);
        cpu_read_check("ovf_err_clr", 3'd6, 9'h000);
        link_if.tx_ready = 1'b1;
        repeat (10) tick();
        check("ovf_drain_count", 32'(seen_q.size()), 32'd5);
        check_seen("ovf_drain_0", 0, 1, 'h055);
        for (int i = 0; i < 4; i++) check_seen("ovf_drain", i + 1, 0, 'h0A0 + i);

        // Input routing, bad channel, underflow.
        rx_send(2'd1, 9'h101);
        rx_send(2'd1, 9'h102);
        rx_send(2'd3, 9'h1FF);
        peek_check("rx_status", 3'd7, 9'h002);
        cpu_read_check("rx_rd0", 3'd1, 9'h101);
        cpu_read_check("rx_rd1", 3'd1, 9'h102);
        cpu_read_check("badch_err", 3'd6, 9'h004);
        cpu_read_check("rx_rd_empty", 3'd1, 9'h000);
        cpu_read_check("udf_err", 3'd6, 9'h002);

`ifdef PICO9_IO_SCHED_IRQ_EN
        cpu_write(3'd7, 9'h002);
        rx_send(2'd1, 9'h0AB);
        @(negedge clk);
        check("irq_pre", 32'(irq), 32'd0);
        tick();
        @(negedge clk);
        check("irq_set", 32'(irq), 32'd1);
        tick();
        cpu_read_check("irq_pop", 3'd1, 9'h0AB);
        tick();
        @(negedge clk);
        check("irq_clr", 32'(irq), 32'd0);
        tick();
        rx_send(2'd1, 9'h0CD);
        cpu_write(3'd0, 9'h0CE);
        cpu_write(3'd7, 9'h100);
        peek_check("irq_flush_status", 3'd7, 9'h000);
        rx_send(2'd1, 9'h0EF);
        repeat (3) tick();
        @(negedge clk);
        check("irq_masked", 32'(irq), 32'd0);
        tick();
        cpu_read_check("irq_rd", 3'd1, 9'h0EF);
`endif

        // Flush keeps the pending output word.
        seen_q.delete();
        link_if.tx_ready = 1'b0;
        cpu_write(3'd1, 9'h033);
        cpu_write(3'd0, 9'h044);
        cpu_write(3'd0, 9'h045);
        rx_send(2'd0, 9'h066);
        cpu_write(3'd7, 9'h100);
        peek_check("flush_status", 3'd7, 9'h100);
        link_if.tx_ready = 1'b1;
        repeat (5) tick();
        check("flush_drain_count", 32'(seen_q.size()), 32'd1);
        check_seen("flush_drain", 0, 1, 'h033);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            op = $urandom_range(0, 3);
            port = 3'($urandom_range(0, 7));
            iowr = (op == 1);
            iord = (op == 2);
            cpu_wdata = 9'($urandom);
            if (port == 3'd7) cpu_wdata[8] = 1'b0;
            link_if.rx_valid = 1'($urandom_range(0, 1));
            link_if.rx_ch = 2'($urandom);
            link_if.rx_data = 9'($urandom);
            link_if.tx_ready = (c < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
        end
        iowr = 1'b0;
        iord = 1'b0;
        link_if.rx_valid = 1'b0;
        link_if.tx_ready = 1'b1;
        repeat (30) tick();
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
